// File: rtl/bldc_commutation_sequencer_if.sv
// Control and gate-drive bundle between the motor controller and the six-step sequencer.
// The sequencer is the slave; the controller (or bench) is the master.
interface bldc_commutation_sequencer_if #(
    parameter int PERIOD_W = 16
);
    logic                enable_i;
    logic                dir_i;
    logic [PERIOD_W-1:0] period_i;
    logic                duty_i;
    logic                fault_i;
    logic                fault_clr_i;

    logic [2:0]          rotate_state_o;
    logic                step_o;
    logic                fault_o;
    logic                HIN_R;
    logic                HIN_S;
    logic                HIN_T;
    logic                _LIN_R;
    logic                _LIN_S;
    logic                _LIN_T;

    modport master (
        output enable_i, dir_i, period_i, duty_i, fault_i, fault_clr_i,
        input  rotate_state_o, step_o, fault_o,
        input  HIN_R, HIN_S, HIN_T, _LIN_R, _LIN_S, _LIN_T
    );

    modport slave (
        input  enable_i, dir_i, period_i, duty_i, fault_i, fault_clr_i,
        output rotate_state_o, step_o, fault_o,
        output HIN_R, HIN_S, HIN_T, _LIN_R, _LIN_S, _LIN_T
    );
endinterface

// File: rtl/bldc_commutation_sequencer.sv
// Open-loop six-step BLDC commutation sequencer with dead-time blanking,
// enable gating and latched fault shutdown; every output is registered.
module bldc_commutation_sequencer #(
    parameter int DEAD_CYC = 8,
    parameter int PERIOD_W = 16
) (
    input logic                         clk_i,
    input logic                         rst_n_i,
    bldc_commutation_sequencer_if.slave bus
);
    localparam int DW = $clog2(DEAD_CYC + 1);
    localparam logic [DW-1:0]       DEAD_LOAD  = DW'(DEAD_CYC);
    localparam logic [DW-1:0]       DEAD_ONE   = DW'(1);
    localparam logic [PERIOD_W-1:0] PERIOD_ONE = PERIOD_W'(1);

    // State name = high phase then low phase of the bridge.
    typedef enum logic [2:0] {
        S_RS = 3'd0,
        S_RT = 3'd1,
        S_ST = 3'd2,
        S_SR = 3'd3,
        S_TR = 3'd4,
        S_TS = 3'd5
    } rot_t;

    rot_t                state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]       dead_q, dead_d;
    logic                fault_q, fault_d;
    logic                en_q;
    logic                step_q;
    logic [2:0]          hin_q, lin_n_q;
    logic                run, commute, reload, drive_ok;
    logic [2:0]          hi_sel, lo_sel;

    function automatic rot_t rot_next(rot_t s, logic rev);
        rot_t r;
        r = s;
        case (s)
            S_RS:    r = rev ? S_TS : S_RT;
            S_RT:    r = rev ? S_RS : S_ST;
            S_ST:    r = rev ? S_RT : S_SR;
            S_SR:    r = rev ? S_ST : S_TR;
            S_TR:    r = rev ? S_SR : S_TS;
            S_TS:    r = rev ? S_TR : S_RS;
            default: r = S_RS;
        endcase
        return r;
    endfunction

    always_comb begin
        fault_d = bus.fault_i | (fault_q & ~bus.fault_clr_i);
        // A fault sampled this edge already freezes the counter and state.
        run     = bus.enable_i & ~fault_q & ~bus.fault_i & (bus.period_i != '0);
        commute = run & (cnt_q >= (bus.period_i - PERIOD_ONE));
        cnt_d   = '0;
        if (run && !commute) begin
            cnt_d = cnt_q + PERIOD_ONE;
        end
        state_d = commute ? rot_next(state_q, bus.dir_i) : state_q;

        reload = commute
               | (bus.enable_i & ~en_q)
               | (fault_q & ~bus.fault_i & bus.fault_clr_i);
        if (reload) begin
            dead_d = DEAD_LOAD;
        end else if (dead_q != '0) begin
            dead_d = dead_q - DEAD_ONE;
        end else begin
            dead_d = dead_q;
        end

        // Gates are derived from next-state values so the old pattern is dropped at the commutation edge itself.
        drive_ok = bus.enable_i & ~fault_d & (dead_d == '0);

        hi_sel = 3'b000;
        lo_sel = 3'b000;
        case (state_d)
            S_RS:    begin hi_sel = 3'b100; lo_sel = 3'b010; end
            S_RT:    begin hi_sel = 3'b100; lo_sel = 3'b001; end
            S_ST:    begin hi_sel = 3'b010; lo_sel = 3'b001; end
            S_SR:    begin hi_sel = 3'b010; lo_sel = 3'b100; end
            S_TR:    begin hi_sel = 3'b001; lo_sel = 3'b100; end
            S_TS:    begin hi_sel = 3'b001; lo_sel = 3'b010; end
            default: begin hi_sel = 3'b000; lo_sel = 3'b000; end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_RS;
            cnt_q   <= '0;
            dead_q  <= '0;
            fault_q <= 1'b0;
            en_q    <= 1'b0;
            step_q  <= 1'b0;
            hin_q   <= 3'b000;
            lin_n_q <= 3'b111;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dead_q  <= dead_d;
            fault_q <= fault_d;
            en_q    <= bus.enable_i;
            step_q  <= commute;
            hin_q   <= hi_sel & {3{drive_ok & bus.duty_i}};
            lin_n_q <= ~(lo_sel & {3{drive_ok}});
        end
    end

    assign bus.rotate_state_o = state_q;
    assign bus.step_o         = step_q;
    assign bus.fault_o        = fault_q;
    assign bus.HIN_R          = hin_q[2];
    assign bus.HIN_S          = hin_q[1];
    assign bus.HIN_T          = hin_q[0];
    assign bus._LIN_R         = lin_n_q[2];
    assign bus._LIN_S         = lin_n_q[1];
    assign bus._LIN_T         = lin_n_q[0];
endmodule

// File: tb/tb_bldc_commutation_sequencer.sv
// Bench for the six-step sequencer: reference model feeds an expected queue each
// clock, plus directed checks of commutation timing, dead time, fault and period handling.
module tb_bldc_commutation_sequencer;
    localparam int DEAD_CYC = 8;
    localparam int PERIOD_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bldc_commutation_sequencer_if #(.PERIOD_W(PERIOD_W)) bus ();

    bldc_commutation_sequencer #(
        .DEAD_CYC(DEAD_CYC),
        .PERIOD_W(PERIOD_W)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;

    // Expected {state[2:0], step, fault, HIN_R/S/T, _LIN_R/S/T}
    logic [10:0] exp_q[$];

    // Bridge phase indices R=0, S=1, T=2 for the high and low side of each state.
    int hi_tab[6] = '{0, 0, 1, 1, 2, 2};
    int lo_tab[6] = '{1, 2, 2, 0, 0, 1};

    int       m_state, m_cnt, m_dead;
    bit       m_fault, m_en_q, m_step;
    bit [2:0] m_hin, m_lin;

    localparam logic [5:0] G_OFF = 6'b000_111;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] dut_vec();
        return {bus.rotate_state_o, bus.step_o, bus.fault_o,
                bus.HIN_R, bus.HIN_S, bus.HIN_T, bus._LIN_R, bus._LIN_S, bus._LIN_T};
    endfunction

    function automatic logic [5:0] gates();
        return {bus.HIN_R, bus.HIN_S, bus.HIN_T, bus._LIN_R, bus._LIN_S, bus._LIN_T};
    endfunction

    task automatic model_edge();
        bit commute;
        bit reload;
        bit was_fault;
        commute   = 1'b0;
        reload    = 1'b0;
        was_fault = m_fault;
        if (!rst_n) begin
            m_state = 0; m_cnt = 0; m_dead = 0;
            m_fault = 1'b0; m_en_q = 1'b0; m_step = 1'b0;
            m_hin = 3'b000; m_lin = 3'b111;
        end else begin
            if (bus.enable_i && !was_fault && !bus.fault_i && bus.period_i != 0) begin
                if (m_cnt >= int'(bus.period_i) - 1) begin
                    commute = 1'b1;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end else begin
                m_cnt = 0;
            end
            if (bus.fault_i) begin
                m_fault = 1'b1;
            end else if (bus.fault_clr_i && was_fault) begin
                m_fault = 1'b0;
                reload = 1'b1;
            end
            if (bus.enable_i && !m_en_q) reload = 1'b1;
            m_en_q = bus.enable_i;
            if (commute) begin
                m_state = bus.dir_i ? (m_state + 5) % 6 : (m_state + 1) % 6;
                reload = 1'b1;
            end
            m_step = commute;
            if (reload) m_dead = DEAD_CYC;
            else if (m_dead > 0) m_dead--;
            m_hin = 3'b000;
            m_lin = 3'b111;
            if (bus.enable_i && !m_fault && m_dead == 0) begin
                m_hin[2 - hi_tab[m_state]] = bus.duty_i;
                m_lin[2 - lo_tab[m_state]] = 1'b0;
            end
        end
        exp_q.push_back({m_state[2:0], m_step, m_fault, m_hin, m_lin});
    endtask

    task automatic tick(int n = 1);
        logic [10:0] exp;
        logic [5:0]  g;
        for (int i = 0; i < n; i++) begin
            model_edge();
            @(posedge clk);
            #1;
            exp = exp_q.pop_front();
            check("scoreboard", dut_vec(), exp);
            g = gates();
            check("shoot_through", g[5:3] & ~g[2:0], 3'b000);
        end
    endtask

    initial begin
        bus.enable_i    = 1'b1;
        bus.dir_i       = 1'b0;
        bus.period_i    = 16'd100;
        bus.duty_i      = 1'b1;
        bus.fault_i     = 1'b0;
        bus.fault_clr_i = 1'b0;

        // Reset values, enable already high
        tick(3);
        check("reset_vec", dut_vec(), 11'h007);

        // Forward rotation at period 100
        rst_n = 1'b1;
        tick(99);
        check("pre_step_state0", {bus.rotate_state_o, bus.step_o, gates()}, {3'd0, 1'b0, 6'b100_101});
        tick(1);
        check("first_step", {bus.rotate_state_o, bus.step_o}, {3'd1, 1'b1});
        check("gates_off_at_step", gates(), G_OFF);
        tick(7);
        check("dead_last_cycle", gates(), G_OFF);
        tick(1);
        check("state1_pattern", gates(), 6'b100_110);
        tick(92);
        check("step_state2", {bus.rotate_state_o, bus.step_o}, {3'd2, 1'b1});
        for (int s = 3; s <= 6; s++) begin
            tick(100);
            check("fwd_sequence", {bus.rotate_state_o, bus.step_o}, {3'(s % 6), 1'b1});
        end

        // Reverse rotation and mid-step direction change
        bus.dir_i = 1'b1;
        tick(100);
        check("rev_0_to_5", bus.rotate_state_o, 3'd5);
        tick(100);
        check("rev_5_to_4", bus.rotate_state_o, 3'd4);
        tick(50);
        bus.dir_i = 1'b0;
        tick(49);
        check("dir_no_early_step", {bus.rotate_state_o, bus.step_o}, {3'd4, 1'b0});
        tick(1);
        check("dir_change_fwd", {bus.rotate_state_o, bus.step_o}, {3'd5, 1'b1});

        // Duty chopping in state 5 (T high, S low)
        tick(10);
        for (int i = 0; i < 20; i++) begin
            bus.duty_i = 1'($urandom_range(0, 1));
            tick(1);
            check("duty_follow", gates(), {2'b00, bus.duty_i, 3'b101});
        end
        bus.duty_i = 1'b1;
        tick(1);

        // One-cycle fault pulse, blocked clear, then real clear
        bus.fault_i = 1'b1;
        tick(1);
        bus.fault_i = 1'b0;
        check("fault_latched", {bus.rotate_state_o, bus.fault_o, gates()}, {3'd5, 1'b1, G_OFF});
        tick(20);
        check("fault_frozen", {bus.rotate_state_o, bus.fault_o, bus.step_o}, {3'd5, 1'b1, 1'b0});
        bus.fault_i = 1'b1;
        bus.fault_clr_i = 1'b1;
        tick(1);
        check("fault_wins_clear", bus.fault_o, 1'b1);
        bus.fault_i = 1'b0;
        tick(1);
        bus.fault_clr_i = 1'b0;
        check("fault_cleared", {bus.fault_o, gates()}, {1'b0, G_OFF});
        tick(7);
        check("clear_dead_time", gates(), G_OFF);
        tick(1);
        check("clear_redrive", gates(), 6'b001_101);
        tick(91);
        check("restart_no_step", {bus.rotate_state_o, bus.step_o}, {3'd5, 1'b0});
        tick(1);
        check("restart_step", {bus.rotate_state_o, bus.step_o}, {3'd0, 1'b1});

        // Period shortened mid-step, then period 0 holds with drive active
        bus.period_i = 16'd1000;
        tick(500);
        bus.period_i = 16'd10;
        tick(1);
        check("short_period_step", {bus.rotate_state_o, bus.step_o}, {3'd1, 1'b1});
        bus.period_i = 16'd0;
        tick(300);
        check("period0_hold", {bus.rotate_state_o, bus.step_o, gates()}, {3'd1, 1'b0, 6'b100_110});

        // Period 1 and reset in the middle of dead time
        bus.period_i = 16'd1;
        tick(5);
        check("period1_steps", {bus.rotate_state_o, bus.step_o, gates()}, {3'd0, 1'b1, G_OFF});
        rst_n = 1'b0;
        tick(1);
        check("reset_mid_dead", dut_vec(), 11'h007);
        rst_n = 1'b1;
        tick(1);
        check("post_reset_step", {bus.rotate_state_o, bus.step_o, gates()}, {3'd1, 1'b1, G_OFF});

        // Random mix of all inputs against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) bus.period_i = 16'($urandom_range(0, 12));
            bus.enable_i    = ($urandom_range(0, 15) != 0);
            bus.dir_i       = 1'($urandom_range(0, 1));
            bus.duty_i      = 1'($urandom_range(0, 1));
            bus.fault_i     = ($urandom_range(0, 40) == 0);
            bus.fault_clr_i = ($urandom_range(0, 4) == 0);
            tick(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
